dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter and sequencer that shares the single-port `dmem` between two requesters, such as the core load/store path on port 0 and a debug/loader port on port 1. Each port uses a valid/ready request channel and a valid/ready response channel. Exactly one transaction is in flight at a time. The block drives the `dmem` control strobes for one cycle per transaction, registers the load data and returns it to the winning port.

## Interface
Parameters:
- `width`, default 32: data width of write data and read data.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p0_req_valid` / `p1_req_valid`  in  1  the port presents a request.
- `p0_req_ready` / `p1_req_ready`  out  1  the arbiter accepts the request this cycle.
- `p0_req_we` / `p1_req_we`  in  1  selects the operation: 1 = store, 0 = load.
- `p0_req_addr` / `p1_req_addr`  in  32  byte address, passed through unmodified.
- `p0_req_wdata` / `p1_req_wdata`  in  width  store data.
- `p0_rsp_valid` / `p1_rsp_valid`  out  1  a response is pending for that port.
- `p0_rsp_ready` / `p1_rsp_ready`  in  1  the port consumes the response.
- `p0_rsp_rdata` / `p1_rsp_rdata`  out  width  load data; 0 for store responses.
- `mem_addr`  out  32  drives the `dmem` `addr` input.
- `mem_is_s_instr`  out  1  store strobe to `dmem`.
- `mem_is_load`  out  1  load strobe to `dmem`.
- `mem_src2_value`  out  width  store data to `dmem`.
- `mem_ld_data`  in  width  combinational read data from `dmem`.

## Operation
State machine:
- States are `IDLE`, `ACCESS` and `RESP`.
- Reset state is `IDLE`.

IDLE:
- Arbitration runs over `pN_req_valid`.
- Only the winning port sees `req_ready` = 1. The loser's ready is 0.
- On accept, the block registers port id, `we`, `addr` and `wdata`, updates `last_grant`, and moves to `ACCESS`.

ACCESS (exactly one cycle):
- `mem_addr` and `mem_src2_value` come from the request registers.
- `mem_is_s_instr` = `we`.
- `mem_is_load` = `!we`.
- At the next edge the `dmem` write commits. For a load, `mem_ld_data` is captured into `rsp_rdata`; for a store, `rsp_rdata` is set to 0. The state moves to `RESP`.

RESP:
- `rsp_valid` is high for the granted port only. `rsp_rdata` is held stable.
- When the granted port's `rsp_ready` is 1, the response completes and the state returns to `IDLE`.

Round-robin rule:
- `last_grant` resets to 1, so port 0 wins the first contention.
- When both ports request, the port ≠ `last_grant` wins.
- When only one port requests, it wins regardless of history.

Outputs outside `ACCESS`:
- `mem_is_s_instr` and `mem_is_load` are 0.
- `mem_addr` and `mem_src2_value` hold the last registered values. Both reset to 0.

Other rules:
- Strobes are gated by `!reset`, so no store is issued in a reset cycle.
- `req_ready` depends only on state and the `req_valid` inputs. It never depends on `rsp_ready`.
- The request registers are not modified outside an accept.

## Timing
- Accept at edge E0: `req_valid` and `req_ready` are both 1.
- Cycle E0→E1 is `ACCESS`. Store data is written at E1; load data is captured at E1.
- `rsp_valid` rises after E1. Latency from accept to `rsp_valid` is 1 cycle.
- If `rsp_ready` is already 1, the response completes at E2, the state is `IDLE` during E2→E3, and the next accept occurs at E3 at the earliest. Peak throughput is one transaction per 3 cycles.
- Back-pressure: `rsp_valid` and `rsp_rdata` hold indefinitely while `rsp_ready` is 0. No other request is accepted during this time.
- A request that is not accepted must stay asserted, and its fields must stay stable, until accepted.
- Reset values are:
  - all `req_ready` = 0, all `rsp_valid` = 0, all `rsp_rdata` = 0;
  - `mem_*` outputs = 0;
  - state = `IDLE`, `last_grant` = 1.
- Reset in `ACCESS` or `RESP` abandons the transaction. There is no response and no store strobe in the reset cycle. The next cycle is `IDLE`.
- `req_ready` is combinational from state and valid. It is 0 in any cycle with `reset` high.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; port 0 always wins contention.
  - `last_grant` is not implemented, and port 1 can starve.
- `DMEM_ARB_FIXED_PRIO_EN` undefined (default):
  - Round-robin as described in Operation.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Port 0 store then load.**
  - Stimulus: p0 stores 0xDEADBEEF to addr 0x10, then loads addr 0x10; p1 idle.
  - Required:
    - `mem_is_s_instr` is high for exactly 1 cycle with `mem_addr` = 0x10.
    - The store response has `p0_rsp_rdata` = 0.
    - The load response has `p0_rsp_rdata` = 0xDEADBEEF, with `rsp_valid` 1 cycle after accept.
- **Contention.**
  - Stimulus: both ports issue loads continuously from reset, with `rsp_ready` held at 1.
  - Required:
    - Grant order is p0, p1, p0, p1.
    - Accepts are 3 cycles apart.
    - `req_ready` is never high on both ports in the same cycle.
- **Back-pressure.**
  - Stimulus: p1 loads addr 0x20 holding 0x12345678; `p1_rsp_ready` is held at 0 for 5 cycles; p0 requests meanwhile.
  - Required:
    - `p1_rsp_valid` and `rsp_rdata` 0x12345678 stay stable for all 5 cycles.
    - `p0_req_ready` stays 0 until the cycle after the p1 response completes.
- **Reset mid-transaction.**
  - Stimulus: assert `reset` in the `ACCESS` cycle of a p0 store of 0xA5A5A5A5 to addr 0x04.
  - Required:
    - `mem_is_s_instr` = 0 in that cycle.
    - No `rsp_valid` is ever issued for that store.
    - A subsequent load of 0x04 returns 0.
- **Fixed-priority build** (`DMEM_ARB_FIXED_PRIO_EN` defined).
  - Stimulus: both ports request continuously.
  - Required: port 0 wins every arbitration; p1 `req_ready` stays 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer sharing a single-port dmem, one transaction in flight.
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins contention).
module dmem_arbiter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic             p0_req_we,
    input  logic [31:0]      p0_req_addr,
    input  logic [width-1:0] p0_req_wdata,
    output logic             p0_rsp_valid,
    input  logic             p0_rsp_ready,
    output logic [width-1:0] p0_rsp_rdata,

    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic             p1_req_we,
    input  logic [31:0]      p1_req_addr,
    input  logic [width-1:0] p1_req_wdata,
    output logic             p1_rsp_valid,
    input  logic             p1_rsp_ready,
    output logic [width-1:0] p1_rsp_rdata,

    output logic [31:0]      mem_addr,
    output logic             mem_is_s_instr,
    output logic             mem_is_load,
    output logic [width-1:0] mem_src2_value,
    input  logic [width-1:0] mem_ld_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             grant_port;
    logic             accept;
    logic             rsp_done;

    logic             req_port_q;
    logic             req_we_q;
    logic [31:0]      req_addr_q;
    logic [width-1:0] req_wdata_q;
    logic [width-1:0] rsp_rdata_q;

    // grant_port: 0 selects port 0, 1 selects port 1; only meaningful when a request is present
`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_port = !p0_req_valid;
    end
`else
    logic last_grant;

    always_comb begin
        if (p0_req_valid && p1_req_valid) begin
            grant_port = ~last_grant;
        end else begin
            grant_port = !p0_req_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant_port;
        end
    end
`endif

    // Every control output is forced low while reset is high, so an abandoned access never strobes.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        rsp_done       = 1'b0;
        p0_req_ready   = 1'b0;
        p1_req_ready   = 1'b0;
        p0_rsp_valid   = 1'b0;
        p1_rsp_valid   = 1'b0;
        mem_is_s_instr = 1'b0;
        mem_is_load    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (p0_req_valid || p1_req_valid) begin
                        accept       = 1'b1;
                        p0_req_ready = !grant_port;
                        p1_req_ready = grant_port;
                        state_nxt    = ACCESS;
                    end
                end
                ACCESS: begin
                    mem_is_s_instr = req_we_q;
                    mem_is_load    = !req_we_q;
                    state_nxt      = RESP;
                end
                RESP: begin
                    p0_rsp_valid = !req_port_q;
                    p1_rsp_valid = req_port_q;
                    rsp_done     = req_port_q ? p1_rsp_ready : p0_rsp_ready;
                    if (rsp_done) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request registers change only on accept; they also feed the dmem address/data pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_port_q  <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else if (accept) begin
            req_port_q  <= grant_port;
            req_we_q    <= grant_port ? p1_req_we    : p0_req_we;
            req_addr_q  <= grant_port ? p1_req_addr  : p0_req_addr;
            req_wdata_q <= grant_port ? p1_req_wdata : p0_req_wdata;
        end
    end

    // Load data is captured at the end of ACCESS and held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata_q <= '0;
        end else if (state == ACCESS) begin
            rsp_rdata_q <= req_we_q ? '0 : mem_ld_data;
        end
    end

    assign mem_addr       = req_addr_q;
    assign mem_src2_value = req_wdata_q;
    assign p0_rsp_rdata   = req_port_q ? '0 : rsp_rdata_q;
    assign p1_rsp_rdata   = req_port_q ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, scoreboard, and multi-cycle corner sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic [31:0] mem_addr, mem_src2_value, mem_ld_data;
    logic        mem_is_s_instr, mem_is_load;

    always #5 clk = ~clk;

    dmem_arbiter #(.width(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .mem_addr(mem_addr), .mem_is_s_instr(mem_is_s_instr), .mem_is_load(mem_is_load),
        .mem_src2_value(mem_src2_value), .mem_ld_data(mem_ld_data)
    );

    // Behavioural single-port dmem: combinational read, write on the clock edge.
    logic [31:0] tb_mem [0:63] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_is_s_instr) tb_mem[mem_addr[7:2]] <= mem_src2_value;
    end
    assign mem_ld_data = tb_mem[mem_addr[7:2]];

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_store_cyc = 0;
    int          both_rdy = 0;
    int          p1_rdy_cnt = 0;
    exp_t        sb[$];
    bit          acc_port_q[$];
    int          acc_cyc_q[$];
    logic [31:0] model_mem [0:63];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic on_accept(input bit port, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        acc_port_q.push_back(port);
        acc_cyc_q.push_back(cyc);
        if (we) begin
            model_mem[addr[7:2]] = wdata;
            sb.push_back('{port: port, rdata: 32'h0});
        end else begin
            sb.push_back('{port: port, rdata: model_mem[addr[7:2]]});
        end
    endtask

    task automatic on_rsp(input bit port, input logic [31:0] rdata);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
        end else begin
            e = sb.pop_front();
            check("sb_port", port, e.port);
            check("sb_rdata", rdata, e.rdata);
        end
    endtask

    // Runs once per cycle at the falling edge, where handshakes are stable.
    task automatic sample();
        cyc++;
        if (!reset) begin
            if (p0_req_ready && p1_req_ready) both_rdy++;
            if (p1_req_ready) p1_rdy_cnt++;
            if (mem_is_s_instr) n_store_cyc++;
            if (p0_req_valid && p0_req_ready) on_accept(0, p0_req_we, p0_req_addr, p0_req_wdata);
            if (p1_req_valid && p1_req_ready) on_accept(1, p1_req_we, p1_req_addr, p1_req_wdata);
            if (p0_rsp_valid && p0_rsp_ready) on_rsp(0, p0_rsp_rdata);
            if (p1_rsp_valid && p1_rsp_ready) on_rsp(1, p1_rsp_rdata);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input bit port, input bit v, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata);
        if (port) begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
        end else begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
        end
    endtask

    function automatic bit rdy(input bit port);
        return port ? p1_req_ready : p0_req_ready;
    endfunction

    function automatic bit rspv(input bit port);
        return port ? p1_rsp_valid : p0_rsp_valid;
    endfunction

    task automatic wait_ready(input bit port, input string name);
        int t = 0;
        #1;
        while (!rdy(port) && t < 50) begin
            tick();
            t++;
        end
        check(name, rdy(port), 1);
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
        drive_req(port, 1, we, addr, wdata);
        if (port) p1_rsp_ready = 1'b1; else p0_rsp_ready = 1'b1;
        wait_ready(port, "txn_accept");
        tick();
        drive_req(port, 0, 0, 32'h0, 32'h0);
        #1;
        check("access_s_instr", mem_is_s_instr, we);
        check("access_load", mem_is_load, !we);
        check("access_addr", mem_addr, addr);
        if (we) check("access_wdata", mem_src2_value, wdata);
        lat = 0;
        while (!rspv(port) && lat < 50) begin
            tick();
            lat++;
        end
        rdata = port ? p1_rsp_rdata : p0_rsp_rdata;
        tick();
        #1;
        check("rsp_complete", rspv(port), 0);
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
    endtask

    localparam int NV = 10;
    vec_t        vec [NV];
    logic [31:0] rd;
    int          lat;
    int          st0;
    bit          rv;

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
        vec[0] = '{0, 1, 32'h10, 32'hDEADBEEF, 32'h0};
        vec[1] = '{0, 0, 32'h10, 32'h0,        32'hDEADBEEF};
        vec[2] = '{1, 1, 32'h14, 32'hCAFEF00D, 32'h0};
        vec[3] = '{1, 0, 32'h14, 32'h0,        32'hCAFEF00D};
        vec[4] = '{0, 0, 32'h14, 32'h0,        32'hCAFEF00D};
        vec[5] = '{1, 0, 32'h10, 32'h0,        32'hDEADBEEF};
        vec[6] = '{0, 1, 32'h10, 32'h0,        32'h0};
        vec[7] = '{1, 0, 32'h10, 32'h0,        32'h0};
        vec[8] = '{0, 1, 32'h3C, 32'hFFFFFFFF, 32'h0};
        vec[9] = '{1, 0, 32'h3C, 32'h0,        32'hFFFFFFFF};

        // Reset values, with requests already present
        reset = 1'b1;
        drive_req(0, 1, 0, 32'h10, 32'h0);
        drive_req(1, 1, 1, 32'h14, 32'h5);
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        @(posedge clk); #2;
        tick();
        check("rst_p0_req_ready", p0_req_ready, 0);
        check("rst_p1_req_ready", p1_req_ready, 0);
        check("rst_rsp_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
        check("rst_rsp_rdata", {p0_rsp_rdata, p1_rsp_rdata}, 0);
        check("rst_mem_strobes", {mem_is_s_instr, mem_is_load}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_src2_value, 0);
        drive_req(0, 0, 0, 32'h0, 32'h0);
        drive_req(1, 0, 0, 32'h0, 32'h0);
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
        reset = 1'b0;
        tick();

        // Single-port vector table
        for (int i = 0; i < NV; i++) begin
            st0 = n_store_cyc;
            do_txn(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, rd, lat);
            check($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rdata);
            check($sformatf("vec%0d_latency", i), lat, 1);
            check($sformatf("vec%0d_store_cycles", i), n_store_cyc - st0, vec[i].we);
            tick();
        end

        // Contention from reset
        reset = 1'b1;
        tick();
        tick();
        acc_port_q.delete();
        acc_cyc_q.delete();
        both_rdy = 0;
        p1_rdy_cnt = 0;
        drive_req(0, 1, 0, 32'h10, 32'h0);
        drive_req(1, 1, 0, 32'h3C, 32'h0);
        p0_rsp_ready = 1'b1;
        p1_rsp_ready = 1'b1;
        reset = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        drive_req(0, 0, 0, 32'h0, 32'h0);
        drive_req(1, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) tick();
        p0_rsp_ready = 1'b0;
        p1_rsp_ready = 1'b0;
        check("cont_accept_count_ge4", acc_port_q.size() >= 4, 1);
        if (acc_port_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                check($sformatf("cont_grant%0d", k), acc_port_q[k], 0);
`else
                check($sformatf("cont_grant%0d", k), acc_port_q[k], k % 2);
`endif
                if (k > 0) check($sformatf("cont_spacing%0d", k), acc_cyc_q[k] - acc_cyc_q[k-1], 3);
            end
        end
        check("cont_both_ready", both_rdy, 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        check("fixed_p1_never_ready", p1_rdy_cnt, 0);
`endif
        tick();

        // Back-pressure on port 1 while port 0 waits
        do_txn(1, 1, 32'h20, 32'h12345678, rd, lat);
        drive_req(1, 1, 0, 32'h20, 32'h0);
        wait_ready(1, "bp_p1_accept");
        tick();
        drive_req(1, 0, 0, 32'h0, 32'h0);
        drive_req(0, 1, 0, 32'h20, 32'h0);
        #1;
        check("bp_p0_ready_access", p0_req_ready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_p1_rsp_valid%0d", k), p1_rsp_valid, 1);
            check($sformatf("bp_p1_rdata%0d", k), p1_rsp_rdata, 32'h12345678);
            check($sformatf("bp_p0_ready%0d", k), p0_req_ready, 0);
            tick();
        end
        p1_rsp_ready = 1'b1;
        #1;
        check("bp_p0_ready_release", p0_req_ready, 0);
        tick();
        p1_rsp_ready = 1'b0;
        p0_rsp_ready = 1'b1;
        #1;
        check("bp_p1_rsp_done", p1_rsp_valid, 0);
        check("bp_p0_ready_after", p0_req_ready, 1);
        tick();
        drive_req(0, 0, 0, 32'h0, 32'h0);
        tick();
        check("bp_p0_rsp_valid", p0_rsp_valid, 1);
        check("bp_p0_rdata", p0_rsp_rdata, 32'h12345678);
        tick();
        p0_rsp_ready = 1'b0;
        tick();

        // Reset during the ACCESS cycle of a store
        drive_req(0, 1, 1, 32'h04, 32'hA5A5A5A5);
        wait_ready(0, "rst_mid_accept");
        tick();
        reset = 1'b1;
        drive_req(0, 0, 0, 32'h0, 32'h0);
        p0_rsp_ready = 1'b1;
        #1;
        check("rst_mid_s_instr", mem_is_s_instr, 0);
        check("rst_mid_load", mem_is_load, 0);
        check("rst_mid_pending", sb.size(), 1);
        tick();
        reset = 1'b0;
        sb.delete();
        model_mem[1] = 32'h0;
        rv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rv = rv | p0_rsp_valid | p1_rsp_valid;
            tick();
        end
        check("rst_mid_no_rsp", rv, 0);
        do_txn(0, 0, 32'h04, 32'h0, rd, lat);
        check("rst_mid_load_rdata", rd, 32'h0);
        tick();

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
